// File: rtl/hex_display_scheduler_pkg.sv
// Shared types and helpers for the hex display scheduler.
package hex_display_scheduler_pkg;

    localparam int unsigned DISP_DATA_W = 32;
    // Widest source vector any instance may use.
    localparam int unsigned MAX_SRC = 8;

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } disp_state_t;

    // One-hot vector with bit idx set; all zero when idx is outside 0..n-1.
    function automatic logic [MAX_SRC-1:0] onehot(input int unsigned idx, input int unsigned n);
        logic [MAX_SRC-1:0] r;
        r = '0;
        if (idx < n && idx < MAX_SRC) begin
            r = MAX_SRC'(1) << idx;
        end
        return r;
    endfunction

endpackage

// File: rtl/hex_display_scheduler_if.sv
// Request/acknowledge bundle between the result sources and the display scheduler.
interface hex_display_scheduler_if
    import hex_display_scheduler_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4
) ();

    logic [NUM_SRC-1:0]             req;
    logic [DISP_DATA_W*NUM_SRC-1:0] req_data;
    logic [NUM_SRC-1:0]             ack;

    // Source side drives requests and data, sees the grant pulse.
    modport master (
        output req,
        output req_data,
        input  ack
    );

    // Scheduler side.
    modport slave (
        input  req,
        input  req_data,
        output ack
    );

endinterface

// File: rtl/hex_display_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set bit of elig at or after ptr,
// wrapping N-1 -> 0. The pointer register lives with the user of the arbiter.
module hex_display_scheduler_rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     elig,
    input  logic [IDX_W-1:0] ptr,
    output logic             gnt_vld,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [N-1:0] rot;

    // Rotate so that the pointer position lands on bit 0.
    always_comb begin
        rot = N'({elig, elig} >> ptr);
    end

    // Lowest set bit of the rotated vector wins; map it back to a source index.
    always_comb begin
        int unsigned sum;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        sum     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!gnt_vld && rot[i[IDX_W-1:0]]) begin
                gnt_vld = 1'b1;
                sum     = 32'(ptr) + i;
                if (sum >= N) begin
                    sum = sum - N;
                end
                gnt_idx = IDX_W'(sum);
            end
        end
    end

endmodule

// File: rtl/hex_display_scheduler.sv
// Shares the 8-digit hex display between several 32-bit result sources. Each granted
// value is held on disp_value for HOLD_CYCLES cycles; switches can pin one source.
module hex_display_scheduler
    import hex_display_scheduler_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 4,
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    localparam int unsigned SRC_W      = $clog2(NUM_SRC),
    localparam int unsigned CNT_W      = $clog2(HOLD_CYCLES + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    // Interface NUM_SRC must match this module's NUM_SRC.
    hex_display_scheduler_if.slave   src,
    input  logic                     pin_en,
    input  logic [SRC_W-1:0]         pin_src,
    input  logic                     flush,
    output logic [DISP_DATA_W-1:0]   disp_value,
    output logic [SRC_W-1:0]         disp_src,
    output logic                     disp_valid,
    output logic                     busy
);

    disp_state_t            state_q;
    logic [SRC_W-1:0]       ptr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [NUM_SRC-1:0]     ack_q;

    logic [NUM_SRC-1:0]     pin_mask;
    logic [NUM_SRC-1:0]     elig;
    logic                   gnt_vld;
    logic [SRC_W-1:0]       gnt_idx;
    logic [DISP_DATA_W-1:0] gnt_data;

    // Eligible set: only the pinned source when pinned (none if the index is out of range).
    always_comb begin
        pin_mask = NUM_SRC'(onehot(32'(pin_src), NUM_SRC));
        elig     = pin_en ? (src.req & pin_mask) : src.req;
    end

    hex_display_scheduler_rr_arbiter #(
        .N (NUM_SRC)
    ) u_arb (
        .elig    (elig),
        .ptr     (ptr_q),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    // Select the winning source's data word.
    always_comb begin
        gnt_data = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (32'(gnt_idx) == i) begin
                gnt_data = src.req_data[i*DISP_DATA_W +: DISP_DATA_W];
            end
        end
    end

    // Grant/dwell state machine with all outputs registered; flush beats everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            ack_q      <= '0;
            disp_value <= '0;
            disp_src   <= '0;
            disp_valid <= 1'b0;
            busy       <= 1'b0;
        end else if (flush) begin
            // disp_src is left alone; disp_valid=0 marks it stale.
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            ack_q      <= '0;
            disp_value <= '0;
            disp_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ack_q <= '0;
                    if (gnt_vld) begin
                        ack_q      <= NUM_SRC'(onehot(32'(gnt_idx), NUM_SRC));
                        disp_value <= gnt_data;
                        disp_src   <= gnt_idx;
                        disp_valid <= 1'b1;
                        // Move past the winner so a still-requesting source goes last.
                        ptr_q      <= (32'(gnt_idx) == NUM_SRC - 1) ? '0 : gnt_idx + 1'b1;
                        cnt_q      <= CNT_W'(HOLD_CYCLES - 1);
                        busy       <= 1'b1;
                        state_q    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    ack_q <= '0;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        busy    <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign src.ack = ack_q;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Self-checking bench for hex_display_scheduler: directed scenarios plus a randomized run
// against a cycle-level behavioural model.
module tb_hex_display_scheduler;
    import hex_display_scheduler_pkg::*;

    localparam int unsigned N     = 4;
    localparam int unsigned HOLD  = 4;
    localparam int unsigned N5    = 5;
    localparam int unsigned HOLD5 = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance: four sources, dwell of four cycles.
    hex_display_scheduler_if #(.NUM_SRC(N)) src_if ();
    logic        pin_en;
    logic [1:0]  pin_src;
    logic        flush;
    logic [31:0] disp_value;
    logic [1:0]  disp_src;
    logic        disp_valid;
    logic        busy;

    hex_display_scheduler #(
        .NUM_SRC     (N),
        .HOLD_CYCLES (HOLD)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src        (src_if),
        .pin_en     (pin_en),
        .pin_src    (pin_src),
        .flush      (flush),
        .disp_value (disp_value),
        .disp_src   (disp_src),
        .disp_valid (disp_valid),
        .busy       (busy)
    );

    // Five-source instance: lets pin_src exceed the source count.
    hex_display_scheduler_if #(.NUM_SRC(N5)) src5_if ();
    logic        pin_en5;
    logic [2:0]  pin_src5;
    logic        flush5;
    logic [31:0] disp_value5;
    logic [2:0]  disp_src5;
    logic        disp_valid5;
    logic        busy5;

    hex_display_scheduler #(
        .NUM_SRC     (N5),
        .HOLD_CYCLES (HOLD5)
    ) u_dut5 (
        .clk        (clk),
        .rst_n      (rst_n),
        .src        (src5_if),
        .pin_en     (pin_en5),
        .pin_src    (pin_src5),
        .flush      (flush5),
        .disp_value (disp_value5),
        .disp_src   (disp_src5),
        .disp_valid (disp_valid5),
        .busy       (busy5)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic set_data(input int unsigned i, input logic [31:0] v);
        src_if.req_data[i*32 +: 32] = v;
    endtask

    task automatic do_flush();
        src_if.req = '0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic test_reset();
        src_if.req      = '0;
        src_if.req_data = '0;
        pin_en  = 1'b0;
        pin_src = '0;
        flush   = 1'b0;
        src5_if.req      = '0;
        src5_if.req_data = '0;
        pin_en5  = 1'b0;
        pin_src5 = '0;
        flush5   = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({src_if.ack, disp_value, disp_src, disp_valid, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ack=%b val=%h src=%0d vld=%b busy=%b, want all 0",
                     src_if.ack, disp_value, disp_src, disp_valid, busy);
        end
        rst_n      = 1'b1;
        src_if.req = 4'b0001;
        set_data(0, 32'h1234_5678);
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_busy: got busy=%b want 1", busy);
        end
        // Assert reset between clock edges; outputs must clear without a clock.
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({src_if.ack, disp_value, disp_src, disp_valid, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got ack=%b val=%h src=%0d vld=%b busy=%b, want all 0",
                     src_if.ack, disp_value, disp_src, disp_valid, busy);
        end
        src_if.req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            n_tests++;
            if ({src_if.ack, busy, disp_valid} !== 3'b0 || disp_src !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_idle: got ack=%b busy=%b vld=%b, want 0", src_if.ack, busy,
                         disp_valid);
            end
        end
        // A request held through reset is arbitrated once reset releases.
        rst_n      = 1'b0;
        src_if.req = 4'b0001;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (src_if.ack !== 4'b0001 || disp_value !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL reset_rearb: got ack=%b val=%h want 0001 12345678", src_if.ack,
                     disp_value);
        end
        src_if.req = '0;
        rst_n      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int busy_cycles;
        set_data(0, 32'hDEAD_BEEF);
        src_if.req = 4'b0001;
        @(negedge clk);
        n_tests++;
        if (src_if.ack !== 4'b0001 || disp_value !== 32'hDEAD_BEEF || disp_src !== 2'd0 ||
            busy !== 1'b1 || disp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: got ack=%b val=%h src=%0d busy=%b vld=%b, want 0001 DEADBEEF 0 1 1",
                     src_if.ack, disp_value, disp_src, busy, disp_valid);
        end
        src_if.req  = '0;
        busy_cycles = (busy === 1'b1) ? 1 : 0;
        repeat (6) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cycles++;
            n_tests++;
            if (src_if.ack !== 4'b0000 || disp_value !== 32'hDEAD_BEEF) begin
                n_fail++;
                $display("FAIL single_hold: got ack=%b val=%h want 0000 DEADBEEF", src_if.ack,
                         disp_value);
            end
        end
        n_tests++;
        if (busy_cycles != HOLD) begin
            n_fail++;
            $display("FAIL single_busy_len: got %0d cycles want %0d", busy_cycles, HOLD);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] d [N];
        int nack;
        int last;
        int exp;
        do_flush();
        for (int i = 0; i < N; i++) begin
            d[i] = ($urandom() & 32'h0FFF_FFFF) | (i << 28);
            set_data(i, d[i]);
        end
        src_if.req = 4'b1111;
        nack = 0;
        last = 0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (src_if.ack !== 4'b0000) begin
                exp = nack % N;
                n_tests++;
                if (src_if.ack !== 4'(1 << exp) || disp_src !== 2'(exp) || disp_value !== d[exp])
                begin
                    n_fail++;
                    $display("FAIL rr_order: ack #%0d got ack=%b src=%0d val=%h want src %0d val %h",
                             nack, src_if.ack, disp_src, disp_value, exp, d[exp]);
                end
                if (nack > 0) begin
                    n_tests++;
                    if (c - last != HOLD + 1) begin
                        n_fail++;
                        $display("FAIL rr_spacing: got %0d cycles want %0d", c - last, HOLD + 1);
                    end
                end
                last = c;
                nack++;
            end
        end
        n_tests++;
        if (nack != 5) begin
            n_fail++;
            $display("FAIL rr_count: got %0d acks want 5", nack);
        end
        src_if.req = '0;
    endtask

    task automatic test_pin();
        logic [31:0] pd;
        int nack;
        do_flush();
        pd = $urandom();
        set_data(2, pd);
        pin_en     = 1'b1;
        pin_src    = 2'd2;
        src_if.req = 4'b1111;
        nack = 0;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (src_if.ack !== 4'b0000) begin
                nack++;
                n_tests++;
                if (src_if.ack !== 4'b0100 || disp_value !== pd) begin
                    n_fail++;
                    $display("FAIL pin_grant: got ack=%b val=%h want 0100 %h", src_if.ack,
                             disp_value, pd);
                end
            end
        end
        n_tests++;
        if (nack != 5) begin
            n_fail++;
            $display("FAIL pin_count: got %0d acks want 5", nack);
        end
        // Pinned source not requesting: nothing is granted.
        do_flush();
        src_if.req = 4'b1011;
        nack = 0;
        repeat (12) begin
            @(negedge clk);
            if (src_if.ack !== 4'b0000) nack++;
        end
        n_tests++;
        if (nack != 0) begin
            n_fail++;
            $display("FAIL pin_absent: got %0d acks want 0", nack);
        end
        pin_en = 1'b0;
        @(negedge clk);
        n_tests++;
        if (src_if.ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL pin_release: got ack=%b want 0001", src_if.ack);
        end
        src_if.req = '0;
        // Out-of-range pin indexes on the five-source instance.
        src5_if.req_data = {32'hA4A4_A4A4, 128'h0};
        src5_if.req      = 5'b11111;
        pin_en5          = 1'b1;
        nack             = 0;
        for (int p = 5; p <= 7; p++) begin
            pin_src5 = 3'(p);
            repeat (4) begin
                @(negedge clk);
                if (src5_if.ack !== 5'b00000) nack++;
            end
        end
        n_tests++;
        if (nack != 0) begin
            n_fail++;
            $display("FAIL pin_out_of_range: got %0d acks want 0", nack);
        end
        pin_src5 = 3'd4;
        @(negedge clk);
        n_tests++;
        if (src5_if.ack !== 5'b10000 || disp_value5 !== 32'hA4A4_A4A4 || disp_src5 !== 3'd4) begin
            n_fail++;
            $display("FAIL pin_last_src: got ack=%b val=%h src=%0d want 10000 A4A4A4A4 4",
                     src5_if.ack, disp_value5, disp_src5);
        end
        src5_if.req = '0;
        pin_en5     = 1'b0;
    endtask

    task automatic test_flush();
        logic [31:0] d1;
        do_flush();
        d1 = $urandom();
        set_data(1, d1);
        src_if.req = 4'b0010;
        @(negedge clk);
        n_tests++;
        if (src_if.ack !== 4'b0010) begin
            n_fail++;
            $display("FAIL flush_first_ack: got ack=%b want 0010", src_if.ack);
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_tests++;
        if (disp_valid !== 1'b0 || disp_value !== 32'h0 || busy !== 1'b0 ||
            src_if.ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL flush_clear: got vld=%b val=%h busy=%b ack=%b want 0 0 0 0000",
                     disp_valid, disp_value, busy, src_if.ack);
        end
        @(negedge clk);
        n_tests++;
        if (src_if.ack !== 4'b0010 || disp_value !== d1 || disp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_regrant: got ack=%b val=%h vld=%b want 0010 %h 1", src_if.ack,
                     disp_value, disp_valid, d1);
        end
        src_if.req = '0;
    endtask

    task automatic test_late_req();
        logic [31:0] d0;
        logic [31:0] d1;
        logic [3:0]  first_ack;
        int          first_c;
        do_flush();
        d0 = $urandom();
        d1 = ~d0;
        set_data(0, d0);
        set_data(1, d1);
        src_if.req = 4'b0001;
        @(negedge clk);
        n_tests++;
        if (src_if.ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL late_first_ack: got ack=%b want 0001", src_if.ack);
        end
        src_if.req = '0;
        @(negedge clk);
        src_if.req = 4'b0010;
        first_c    = -1;
        first_ack  = '0;
        for (int c = 3; c <= 10; c++) begin
            @(negedge clk);
            if (first_c < 0 && src_if.ack !== 4'b0000) begin
                first_c   = c;
                first_ack = src_if.ack;
                src_if.req = '0;
            end
            if (first_c < 0) begin
                n_tests++;
                if (disp_value !== d0) begin
                    n_fail++;
                    $display("FAIL late_hold_value: cycle %0d got %h want %h", c, disp_value, d0);
                end
            end
        end
        n_tests++;
        if (first_c != 1 + HOLD + 1 || first_ack !== 4'b0010) begin
            n_fail++;
            $display("FAIL late_ack: got ack=%b at cycle %0d want 0010 at cycle %0d", first_ack,
                     first_c, 1 + HOLD + 1);
        end
        src_if.req = '0;
    endtask

    task automatic test_random();
        logic [3:0]  rq;
        logic [31:0] dat [N];
        int          m_rr;
        int          m_left;
        int          m_ack;
        int          m_src;
        int          idx;
        logic [31:0] m_value;
        logic        m_valid;
        logic [3:0]  exp_ack;
        rq = '0;
        for (int i = 0; i < N; i++) dat[i] = '0;
        src_if.req = '0;
        pin_en     = 1'b0;
        pin_src    = '0;
        flush      = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        m_rr    = 0;
        m_left  = 0;
        m_ack   = -1;
        m_src   = 0;
        m_value = '0;
        m_valid = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            // Sources: drop or keep after an ack, raise new requests at random.
            for (int i = 0; i < N; i++) begin
                if (src_if.ack[i] === 1'b1) begin
                    if ($urandom_range(1, 0) == 1) rq[i] = 1'b0;
                end else if (!rq[i] && $urandom_range(9, 0) < 3) begin
                    rq[i]  = 1'b1;
                    dat[i] = $urandom();
                end
            end
            if ($urandom_range(9, 0) == 0) begin
                pin_en  = ~pin_en;
                pin_src = 2'($urandom_range(3, 0));
            end
            flush = ($urandom_range(49, 0) == 0);
            src_if.req = rq;
            for (int i = 0; i < N; i++) set_data(i, dat[i]);
            // Reference: what the next clock edge must produce.
            if (flush) begin
                m_ack   = -1;
                m_value = '0;
                m_valid = 1'b0;
                m_left  = 0;
                m_rr    = 0;
            end else if (m_left > 0) begin
                m_ack  = -1;
                m_left = m_left - 1;
            end else begin
                m_ack = -1;
                for (int k = 0; k < N; k++) begin
                    idx = (m_rr + k) % N;
                    if (m_ack < 0 && rq[idx] && (!pin_en || int'(pin_src) == idx)) m_ack = idx;
                end
                if (m_ack >= 0) begin
                    m_value = dat[m_ack];
                    m_src   = m_ack;
                    m_valid = 1'b1;
                    m_rr    = (m_ack + 1) % N;
                    m_left  = HOLD;
                end
            end
            @(negedge clk);
            flush   = 1'b0;
            exp_ack = (m_ack < 0) ? 4'b0000 : 4'(1 << m_ack);
            n_tests++;
            if (src_if.ack !== exp_ack) begin
                n_fail++;
                $display("FAIL rand_ack: cycle %0d got %b want %b", cyc, src_if.ack, exp_ack);
            end
            n_tests++;
            if (disp_value !== m_value || disp_src !== 2'(m_src)) begin
                n_fail++;
                $display("FAIL rand_disp: cycle %0d got val=%h src=%0d want val=%h src=%0d", cyc,
                         disp_value, disp_src, m_value, m_src);
            end
            n_tests++;
            if (disp_valid !== m_valid || busy !== (m_left > 0)) begin
                n_fail++;
                $display("FAIL rand_status: cycle %0d got vld=%b busy=%b want vld=%b busy=%b",
                         cyc, disp_valid, busy, m_valid, (m_left > 0));
            end
        end
        src_if.req = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_pin();
        test_flush();
        test_late_req();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
